// File: rtl/shift_seq_ctrl_pkg.sv
// Shared constants for the shift-register frame sequencer.
// State codes are legacy-compatible 3-bit values.
package shift_ctrl_pkg;

   localparam int ST_W = 3;

   localparam logic [ST_W-1:0] IDLE   = 3'd0;
   localparam logic [ST_W-1:0] LOAD   = 3'd1;
   localparam logic [ST_W-1:0] SHIFT  = 3'd2;
   localparam logic [ST_W-1:0] PARITY = 3'd3;
   localparam logic [ST_W-1:0] DONE   = 3'd4;

   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Word producer handshake into the frame sequencer.
// master = producer, slave = sequencer.
interface shift_seq_ctrl_if #(
   parameter int SHIFT_WIDTH = 8
);

   logic                   in_valid;
   logic                   in_ready;
   logic [SHIFT_WIDTH-1:0] in_data;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );

endinterface

// File: rtl/shift_seq_ctrl_counter.sv
// Shift counter for one frame: clear, increment, and
// a terminal flag on the last shift (SHIFT_WIDTH-1).
module shift_bit_counter #(
   parameter int SHIFT_WIDTH = 8,
   parameter int CNT_W       = 4
) (
   input  logic             clock,
   input  logic             sclr,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             term
);

   always_ff @(posedge clock) begin
      if (sclr || clr)
         cnt <= '0;
      else if (inc)
         cnt <= cnt + 1'b1;
   end

   assign term = (cnt == CNT_W'(SHIFT_WIDTH - 1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Frame sequencer driving a parallel-load shift register.
// Optional parity stage: define SHIFT_CTRL_PARITY_EN.
module shift_seq_ctrl
   import shift_ctrl_pkg::*;
#(
   parameter int   SHIFT_WIDTH     = 8,
   parameter       SHIFT_DIRECTION = "LEFT",
   parameter logic FILL_BIT        = 1'b0,
   localparam int  CNT_W           = cnt_w(SHIFT_WIDTH)
) (
   input  logic                   clock,
   input  logic                   sclr,
   shift_seq_ctrl_if.slave        in_bus,
   input  logic                   out_ready,
   input  logic                   abort,
   output logic                   sr_load,
   output logic                   sr_enable,
   output logic                   sr_sclr,
   output logic                   sr_shiftin,
   output logic [SHIFT_WIDTH-1:0] sr_data,
   output logic                   ser_valid,
   output logic [CNT_W-1:0]       bit_cnt,
   output logic                   busy,
   output logic                   done
`ifdef SHIFT_CTRL_PARITY_EN
   ,
   output logic                   par_valid,
   output logic                   par_bit
`endif
);

   if (SHIFT_WIDTH < 2 || SHIFT_WIDTH > 64) begin : g_bad_width
      $error("shift_seq_ctrl: SHIFT_WIDTH out of range");
   end
   if (SHIFT_DIRECTION != "LEFT" &&
       SHIFT_DIRECTION != "RIGHT") begin : g_bad_dir
      $error("shift_seq_ctrl: bad SHIFT_DIRECTION");
   end

   logic [ST_W-1:0] state;
   logic [ST_W-1:0] state_n;

   logic st_idle;
   logic st_load;
   logic st_shift;
   logic st_par;
   logic st_done;

   logic accept;
   logic kill;
   logic term;

   assign st_idle  = (state == IDLE);
   assign st_load  = (state == LOAD);
   assign st_shift = (state == SHIFT);
   assign st_par   = (state == PARITY);
   assign st_done  = (state == DONE);

   assign accept = st_idle & in_bus.in_valid & ~abort;
   assign kill   = abort & ~st_idle;

   always_comb begin
      state_n = state;
      unique case (1'b1)
         st_idle: begin
            if (accept)
               state_n = LOAD;
         end
         st_load: begin
            state_n = SHIFT;
         end
         st_shift: begin
            if (out_ready && term)
`ifdef SHIFT_CTRL_PARITY_EN
               state_n = PARITY;
`else
               state_n = DONE;
`endif
         end
         st_par: begin
`ifdef SHIFT_CTRL_PARITY_EN
            if (out_ready)
               state_n = DONE;
`else
            state_n = IDLE;
`endif
         end
         st_done: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      // abort outranks every transition, including acceptance
      if (kill)
         state_n = IDLE;
   end

   always_ff @(posedge clock) begin
      if (sclr) begin
         state   <= IDLE;
         sr_data <= '0;
         sr_sclr <= 1'b0;
      end else begin
         state   <= state_n;
         sr_sclr <= kill;
         if (accept)
            sr_data <= in_bus.in_data;
      end
   end

   shift_bit_counter #(
      .SHIFT_WIDTH (SHIFT_WIDTH),
      .CNT_W       (CNT_W)
   ) u_cnt (
      .clock (clock),
      .sclr  (sclr),
      .clr   (accept | kill),
      .inc   (st_shift & out_ready),
      .cnt   (bit_cnt),
      .term  (term)
   );

   // enable follows the sink so stalls freeze the register
   assign sr_enable  = st_load | (st_shift & out_ready);
   assign sr_load    = st_load;
   assign sr_shiftin = st_shift & FILL_BIT;
   assign ser_valid  = st_shift;
   assign busy       = ~st_idle;
   assign done       = st_done;

   assign in_bus.in_ready = st_idle;

`ifdef SHIFT_CTRL_PARITY_EN
   assign par_valid = st_par;
   assign par_bit   = st_par & (^sr_data);
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed frames plus random traffic
// against a frame-level model and a shift register image.
module tb_shift_seq_ctrl;

   localparam int   W    = 8;
   localparam int   CW   = $clog2(W + 1);
   localparam logic FILL = 1'b0;
`ifdef SHIFT_CTRL_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          sclr;
   logic          out_ready;
   logic          abort;
   logic          sr_load;
   logic          sr_enable;
   logic          sr_sclr;
   logic          sr_shiftin;
   logic [W-1:0]  sr_data;
   logic          ser_valid;
   logic [CW-1:0] bit_cnt;
   logic          busy;
   logic          done;
`ifdef SHIFT_CTRL_PARITY_EN
   logic          par_valid;
   logic          par_bit;
`endif

   int errors = 0;
   int checks = 0;

   shift_seq_ctrl_if #(.SHIFT_WIDTH(W)) bus ();

   shift_seq_ctrl #(
      .SHIFT_WIDTH     (W),
      .SHIFT_DIRECTION ("LEFT"),
      .FILL_BIT        (FILL)
   ) dut (
      .clock      (clock),
      .sclr       (sclr),
      .in_bus     (bus),
      .out_ready  (out_ready),
      .abort      (abort),
      .sr_load    (sr_load),
      .sr_enable  (sr_enable),
      .sr_sclr    (sr_sclr),
      .sr_shiftin (sr_shiftin),
      .sr_data    (sr_data),
      .ser_valid  (ser_valid),
      .bit_cnt    (bit_cnt),
      .busy       (busy),
`ifdef SHIFT_CTRL_PARITY_EN
      .done       (done),
      .par_valid  (par_valid),
      .par_bit    (par_bit)
`else
      .done       (done)
`endif
   );

   always #5 clock = ~clock;

   // frame-level model: word held, shifts taken, phase flags
   bit       m_busy;
   bit       m_loaded;
   bit       m_par_done;
   bit       m_pulse;
   int       m_shifts;
   logic [W-1:0] m_word;
   logic [W-1:0] q;
   logic [W-1:0] col;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      bit idle, loadp, shifting, parity, donep;
      bit i_sclr, i_abort, i_valid, i_ordy;
      logic [W-1:0] i_data;
      bit s_load, s_en, s_sclr, s_in;
      logic [W-1:0] s_data;
      @(negedge clock);
      idle     = !m_busy;
      loadp    = m_busy && !m_loaded;
      shifting = m_busy && m_loaded && m_shifts < W;
      parity   = PAR && m_busy && m_loaded &&
                 m_shifts == W && !m_par_done;
      donep    = m_busy && m_loaded && m_shifts == W &&
                 (!PAR || m_par_done);
      chk("in_ready", bus.in_ready, idle);
      chk("sr_load", sr_load, loadp);
      chk("sr_enable", sr_enable,
          loadp || (shifting && out_ready));
      chk("sr_sclr", sr_sclr, m_pulse);
      chk("sr_shiftin", sr_shiftin, shifting && FILL);
      chk("sr_data", sr_data, m_word);
      chk("ser_valid", ser_valid, shifting);
      chk("bit_cnt", bit_cnt, m_shifts);
      chk("busy", busy, m_busy);
      chk("done", done, donep);
      if (donep) begin
         chk("frame_bits", col, m_word);
         chk("q_flushed", q, {W{FILL}});
      end
`ifdef SHIFT_CTRL_PARITY_EN
      chk("par_valid", par_valid, parity);
      chk("par_bit", par_bit, parity && (^m_word));
`endif
      i_sclr  = sclr;
      i_abort = abort;
      i_valid = bus.in_valid;
      i_ordy  = out_ready;
      i_data  = bus.in_data;
      s_load  = sr_load;
      s_en    = sr_enable;
      s_sclr  = sr_sclr;
      s_in    = sr_shiftin;
      s_data  = sr_data;
      @(posedge clock);
      if (shifting && i_ordy)
         col = {col[W-2:0], q[W-1]};
      if (i_sclr || s_sclr)
         q = '0;
      else if (s_load)
         q = s_data;
      else if (s_en)
         q = {q[W-2:0], s_in};
      if (i_sclr) begin
         m_busy     = 1'b0;
         m_loaded   = 1'b0;
         m_par_done = 1'b0;
         m_pulse    = 1'b0;
         m_shifts   = 0;
         m_word     = '0;
      end else begin
         m_pulse = i_abort && m_busy;
         if (i_abort && m_busy) begin
            m_busy   = 1'b0;
            m_shifts = 0;
         end else if (idle) begin
            if (i_valid && !i_abort) begin
               m_busy     = 1'b1;
               m_loaded   = 1'b0;
               m_par_done = 1'b0;
               m_shifts   = 0;
               m_word     = i_data;
            end
         end else if (loadp) begin
            m_loaded = 1'b1;
         end else if (shifting) begin
            if (i_ordy)
               m_shifts++;
         end else if (parity) begin
            if (i_ordy)
               m_par_done = 1'b1;
         end else if (donep) begin
            m_busy = 1'b0;
         end
      end
      #1;
   endtask

   task automatic wait_cnt(input int n);
      for (int i = 0; i < 40; i++) begin
         if (m_busy && m_loaded && m_shifts == n)
            break;
         tick();
      end
      chk("reach_bitcnt", bit_cnt, n);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && m_busy; i++)
         tick();
      chk("reach_idle", busy, 1'b0);
   endtask

   task automatic send(input logic [W-1:0] w);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      m_word       = '0;
      q            = '0;
      col          = '0;
      sclr         = 1'b1;
      abort        = 1'b0;
      out_ready    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      @(posedge clock);
      #1;
      tick();
      tick();
      sclr = 1'b0;
      tick();

      // full frame, sink always ready
      out_ready = 1'b1;
      send(8'hA5);
      repeat (12) tick();

      // stall three cycles mid-frame
      send(8'h3C);
      wait_cnt(4);
      out_ready = 1'b0;
      repeat (3) tick();
      out_ready = 1'b1;
      wait_idle();
      tick();

      // abort mid-frame, then a clean frame
      send(8'h5A);
      wait_cnt(5);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      repeat (2) tick();
      send(8'hC3);
      repeat (12) tick();

      // in_valid held with changing data during a frame
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h96;
      for (int i = 0; i < 14; i++) begin
         tick();
         bus.in_data = W'($urandom);
      end
      bus.in_valid = 1'b0;
      wait_idle();
      abort        = 1'b1;
      bus.in_valid = 1'b1;
      tick();
      abort        = 1'b0;
      bus.in_valid = 1'b0;
      repeat (2) tick();

      // reset in the middle of shifting
      send(8'hE1);
      wait_cnt(3);
      sclr = 1'b1;
      tick();
      sclr = 1'b0;
      repeat (2) tick();

`ifdef SHIFT_CTRL_PARITY_EN
      // parity stage held by backpressure
      send(8'h07);
      wait_cnt(W - 1);
      tick();
      out_ready = 1'b0;
      repeat (2) tick();
      out_ready = 1'b1;
      repeat (3) tick();
`endif

      for (int i = 0; i < 500; i++) begin
         bus.in_valid = ($urandom_range(1, 0) == 1);
         bus.in_data  = W'($urandom);
         out_ready    = ($urandom_range(3, 0) != 0);
         abort        = ($urandom_range(31, 0) == 0);
         sclr         = ($urandom_range(127, 0) == 0);
         tick();
      end
      sclr         = 1'b0;
      abort        = 1'b0;
      bus.in_valid = 1'b0;
      out_ready    = 1'b1;
      wait_idle();

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
